// File: rtl/package_settings.sv
// Global sizes shared by the ADC front end and the filter chain.
// Holds no logic; other packages and modules take their default widths
// from here so a board-level width change is made in one place.
package package_settings;

    localparam int ADC_WIDTH   = 12;   // ADC sample width (unsigned)
    localparam int ACC_WIDTH   = 32;   // filter accumulator width (signed)
    localparam int OUT_WIDTH   = 16;   // filtered output width (signed)
    localparam int DELAY_DEPTH = 32;   // longest K / L the delay line supports

endpackage

// File: rtl/trap_filter_pkg.sv
// Types, constants and helpers for the trapezoidal pulse shaper.
//   trap_state_t : FILL while the delay line/accumulators warm up, RUN after
//   acc_t        : signed accumulator at the default accumulator width
//   PIPE_LATENCY : clocks from an accepted sample to its out_valid
//   sat()        : clamp a signed value to a signed field of a given width
package trap_filter_pkg;

    import package_settings::*;

    typedef enum logic {FILL, RUN} trap_state_t;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam int PIPE_LATENCY = 5;

    // The value is widened to 64 bits so one function serves any
    // accumulator/output width pair up to 64 bits. 'clipped' reports
    // whether clamping took place.
    function automatic logic signed [63:0] sat(
        input  logic signed [63:0] value,
        input  int                 width,
        output logic               clipped
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] result;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (width - 1));
        clipped = 1'b0;
        result  = value;
        if (value > hi) begin
            result  = hi;
            clipped = 1'b1;
        end else if (value < lo) begin
            result  = lo;
            clipped = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Sample history for the shaper.
// Conceptually MAX_DEPTH+1 entries x(n)..x(n-DEPTH): entry 0 is the live
// input (fixed tap 0) and entries 1..DEPTH are registers holding the
// previously shifted-in samples, so runtime taps K, L and L+1 read the
// history as it stands before the current sample is written.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   shift_en     push din into the line
//   clr          synchronous clear of all stored samples
//   din          new sample
//   k, l         runtime tap selects (tap l+1 derived internally)
//   tap_0/k/l/l1 x(n), x(n-k), x(n-l), x(n-l-1)
module sample_delay_line #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic [IDX_W-1:0]  k,
    input  logic [IDX_W-1:0]  l,
    output logic [DATA_W-1:0] tap_0,
    output logic [DATA_W-1:0] tap_k,
    output logic [DATA_W-1:0] tap_l,
    output logic [DATA_W-1:0] tap_l1
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] tap_vec [DEPTH+1];
    logic [IDX_W-1:0]  l_plus1;

    assign tap_vec[0] = din;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign tap_vec[gi+1] = mem_reg[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    mem_reg[gi] <= '0;
                end else if (clr) begin
                    mem_reg[gi] <= '0;
                end else if (shift_en) begin
                    mem_reg[gi] <= tap_vec[gi];
                end
            end
        end
    endgenerate

    assign l_plus1 = l + IDX_W'(1);

    assign tap_0  = tap_vec[0];
    assign tap_k  = tap_vec[k];
    assign tap_l  = tap_vec[l];
    assign tap_l1 = tap_vec[l_plus1];

endmodule

// File: rtl/param_trap_filter.sv
// Runtime-configurable trapezoidal pulse shaper for a valid-qualified ADC
// stream. Five-stage pipeline:
//   S1 tap read, d_k and d_1(n-L) | S2 p | S3 q and M1*p | S4 s |
//   S5 shift + saturate.
// Every stage moves only with its valid bit, so input gaps freeze the
// datapath and latency stays exactly PIPE_LATENCY clocks.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   input_data/in_valid unsigned ADC sample and its qualifier
//   cfg_*/cfg_load      new K, L, M1, M2, shift, latched on the strobe
//   cfg_err             one-clock pulse when a load is rejected
//   output_data         saturated signed result, qualified by out_valid
//   ovf                 output was clamped, qualified by out_valid
//   busy                filter is warming up (state FILL)
module param_trap_filter
    import package_settings::*, trap_filter_pkg::*;
#(
    parameter int DATA_W    = ADC_WIDTH,
    parameter int ACC_W     = ACC_WIDTH,
    parameter int OUT_W     = OUT_WIDTH,
    parameter int MAX_DEPTH = DELAY_DEPTH,
    parameter int DEF_K     = 8,
    parameter int DEF_L     = 4,
    parameter int DEF_M1    = 4,
    parameter int DEF_M2    = 1,
    parameter int DEF_SHIFT = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  input_data,
    input  logic                               in_valid,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]     cfg_k,
    input  logic [$clog2(MAX_DEPTH)-1:0]       cfg_l,
    input  logic [7:0]                         cfg_m1,
    input  logic [7:0]                         cfg_m2,
    input  logic [4:0]                         cfg_shift,
    input  logic                               cfg_load,
    output logic                               cfg_err,
    output logic signed [OUT_W-1:0]            output_data,
    output logic                               out_valid,
    output logic                               ovf,
    output logic                               busy
);

    localparam int K_W   = $clog2(MAX_DEPTH + 1);
    localparam int L_W   = $clog2(MAX_DEPTH);
    localparam int CNT_W = K_W + 1;   // holds K+L up to 2*MAX_DEPTH-1

    // Active configuration and control
    trap_state_t      state_reg;
    logic [K_W-1:0]   k_reg;
    logic [L_W-1:0]   l_reg;
    logic [7:0]       m1_reg;
    logic [7:0]       m2_reg;
    logic [4:0]       shift_reg;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic             cfg_err_reg;

    logic cfg_ok;
    logic accept;
    logic reload;

    // A load always takes priority over a sample in the same clock, even
    // when the load itself is rejected.
    assign cfg_ok = (cfg_k != '0)
                 && (int'(cfg_k) <= MAX_DEPTH)
                 && (int'(cfg_l) <= MAX_DEPTH - 1)
                 && (int'(cfg_shift) <= ACC_W - 1);
    assign accept = in_valid & ~cfg_load;
    assign reload = cfg_load & cfg_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= FILL;
            k_reg        <= K_W'(DEF_K);
            l_reg        <= L_W'(DEF_L);
            m1_reg       <= 8'(DEF_M1);
            m2_reg       <= 8'(DEF_M2);
            shift_reg    <= 5'(DEF_SHIFT);
            fill_cnt_reg <= '0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_load & ~cfg_ok;
            if (reload) begin
                k_reg        <= cfg_k;
                l_reg        <= cfg_l;
                m1_reg       <= cfg_m1;
                m2_reg       <= cfg_m2;
                shift_reg    <= cfg_shift;
                fill_cnt_reg <= '0;
                state_reg    <= FILL;
            end else if (accept && state_reg == FILL) begin
                // Samples 0..K+L are accepted in FILL; the one after the
                // sample with index K+L is the first accepted in RUN.
                if (fill_cnt_reg == CNT_W'(k_reg) + CNT_W'(l_reg)) begin
                    state_reg <= RUN;
                end else begin
                    fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Delay line
    logic [DATA_W-1:0] tap_0, tap_k, tap_l, tap_l1;

    sample_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DEPTH),
        .IDX_W  (K_W)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .clr      (reload),
        .din      (input_data),
        .k        (k_reg),
        .l        (K_W'(l_reg)),
        .tap_0    (tap_0),
        .tap_k    (tap_k),
        .tap_l    (tap_l),
        .tap_l1   (tap_l1)
    );

    // Samples are unsigned; zero-extend before signed arithmetic.
    logic signed [ACC_W-1:0] x_0, x_k, x_l, x_l1;
    logic signed [ACC_W-1:0] k_s, m1_s, m2_s;

    assign x_0  = $signed(ACC_W'(tap_0));
    assign x_k  = $signed(ACC_W'(tap_k));
    assign x_l  = $signed(ACC_W'(tap_l));
    assign x_l1 = $signed(ACC_W'(tap_l1));
    assign k_s  = $signed(ACC_W'(k_reg));
    assign m1_s = $signed(ACC_W'(m1_reg));
    assign m2_s = $signed(ACC_W'(m2_reg));

    // Pipeline state; vld_reg[i]/tag_reg[i] qualify the output of stage i+1.
    logic [PIPE_LATENCY-1:0] vld_reg;
    logic [PIPE_LATENCY-1:0] tag_reg;
    logic signed [ACC_W-1:0] dk_reg, d1_reg, p_reg, q_reg, m1p_reg, s_reg;
    logic signed [OUT_W-1:0] output_data_reg;
    logic                    ovf_reg;

    logic signed [ACC_W-1:0] s_shifted;
    logic signed [OUT_W-1:0] sat_data;
    logic                    sat_ovf;

    assign s_shifted = s_reg >>> shift_reg;

    always_comb begin
        sat_ovf  = 1'b0;
        sat_data = OUT_W'(sat(64'(s_shifted), OUT_W, sat_ovf));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_reg         <= '0;
            tag_reg         <= '0;
            dk_reg          <= '0;
            d1_reg          <= '0;
            p_reg           <= '0;
            q_reg           <= '0;
            m1p_reg         <= '0;
            s_reg           <= '0;
            output_data_reg <= '0;
            ovf_reg         <= 1'b0;
        end else if (reload) begin
            // In-flight samples are discarded along with the old state.
            vld_reg <= '0;
            tag_reg <= '0;
            dk_reg  <= '0;
            d1_reg  <= '0;
            p_reg   <= '0;
            q_reg   <= '0;
            m1p_reg <= '0;
            s_reg   <= '0;
        end else begin
            vld_reg <= {vld_reg[PIPE_LATENCY-2:0], accept};
            tag_reg <= {tag_reg[PIPE_LATENCY-2:0], state_reg == RUN};
            if (accept) begin
                dk_reg <= x_0 - x_k;
                d1_reg <= x_l - x_l1;
            end
            if (vld_reg[0]) begin
                p_reg <= p_reg + dk_reg - k_s * d1_reg;
            end
            if (vld_reg[1]) begin
                q_reg   <= q_reg + m2_s * p_reg;
                m1p_reg <= m1_s * p_reg;
            end
            if (vld_reg[2]) begin
                s_reg <= s_reg + q_reg + m1p_reg;
            end
            if (vld_reg[3]) begin
                output_data_reg <= sat_data;
                ovf_reg         <= sat_ovf;
            end
        end
    end

    assign output_data = output_data_reg;
    assign ovf         = ovf_reg;
    assign out_valid   = vld_reg[PIPE_LATENCY-1] & tag_reg[PIPE_LATENCY-1];
    assign busy        = (state_reg == FILL);
    assign cfg_err     = cfg_err_reg;

endmodule
